// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, byte width and the parity helper
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Even parity is the XOR of all data bits; odd parity inverts it.
    function automatic logic parity_calc(input logic [UART_DATA_W-1:0] data,
                                         input logic                   odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..div while enabled and emits a one-cycle tick on the
// last cycle of each period. The divisor is captured on load_i.
module uart_baud_tick (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [31:0] div_i,
    output logic        tick_o
);

    logic [31:0] count_q;
    logic [31:0] div_q;

    assign tick_o = en_i && (count_q == div_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            div_q   <= '0;
        end else begin
            if (load_i) begin
                div_q <= div_i;
            end
            if (clr_i) begin
                count_q <= '0;
            end else if (en_i) begin
                count_q <= tick_o ? '0 : count_q + 32'd1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop
// bits. All outputs are registered; the line idles high.
module uart_tx
    import uart_pkg::*;
#(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   init_i,
    output logic                   done_o,
    output logic                   busy_o,
    input  logic [UART_DATA_W-1:0] data_i,
    output logic                   data_o,
    input  logic [31:0]            baud_div_i
);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam logic LAST_STOP = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic HAS_PAR   = (PARITY_EN != 0);
    localparam logic ODD_PAR   = (PARITY_ODD != 0);

    tx_state_t              state_q, state_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic                   stop_idx_q, stop_idx_d;
    logic                   parity_q;
    logic                   line_d, done_d, busy_d;
    logic                   accept;
    logic                   tick;

    assign accept = (state_q == TX_IDLE) && init_i;

    uart_baud_tick u_baud (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q != TX_IDLE),
        .clr_i   (accept),
        .load_i  (accept),
        .div_i   (baud_div_i),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            data_o     <= 1'b1;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            data_o     <= line_d;
            done_o     <= done_d;
            busy_o     <= busy_d;
            // Parity comes from the byte as accepted, not from the shifting copy.
            if (accept) begin
                parity_q <= parity_calc(data_i, ODD_PAR);
            end
        end
    end

    // line_d is the value the line takes in the next cycle, so each transition
    // decides the first bit of the state it enters.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        line_d     = data_o;
        done_d     = done_o;
        busy_d     = busy_o;

        case (state_q)
            TX_IDLE: begin
                line_d = 1'b1;
                if (init_i) begin
                    shift_d    = data_i;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    done_d     = 1'b0;
                    busy_d     = 1'b1;
                    line_d     = 1'b0;
                    state_d    = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    bit_idx_d = '0;
                    line_d    = shift_q[0];
                    state_d   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        if (HAS_PAR) begin
                            line_d  = parity_q;
                            state_d = TX_PARITY;
                        end else begin
                            line_d     = 1'b1;
                            stop_idx_d = 1'b0;
                            state_d    = TX_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        line_d    = shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    line_d     = 1'b1;
                    stop_idx_d = 1'b0;
                    state_d    = TX_STOP;
                end
            end
            TX_STOP: begin
                line_d = 1'b1;
                if (tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = TX_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                line_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = TX_IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter, LSB first, start bit 0, optional parity, 1 or 2 stop bits.
- Serial companion of the existing 8-bit UART receiver; uses the same init_i/done_o handshake and the same baud_div_i runtime divisor, so the two blocks pair directly in loopback.
- Sits between a byte-producing controller (register block or FIFO drain) and the TX pad.

Parameters:
- PARITY_EN, 0, 1 inserts a parity bit after D7; 0 means no parity bit.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2; elaboration error otherwise.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  reset, asynchronous, active-low.
- init_i  input  1  start request; single-cycle pulse or level; acted on only in IDLE.
- done_o  output  1  frame complete; held high until the next accepted init_i.
- busy_o  output  1  high from init acceptance through the end of the last stop bit.
- data_i  input  8  byte to send; sampled on the cycle init_i is accepted.
- data_o  output  1  serial line; idles high.
- baud_div_i  input  32  bit period minus one, in clk_i cycles; sampled at init acceptance.

Behaviour:
- Reset values: data_o=1, done_o=0, busy_o=0, state IDLE, counters 0, shift register 0.
- Bit period N = baud_div_i + 1 cycles. baud_div_i = 0 is legal (N = 1).
- The baud divisor and data byte are latched at acceptance; later changes to either input do not affect the current frame.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - init_i=1 latches data_i into the shift register, latches baud_div_i, clears done_o, sets busy_o, and moves to START.
  - Acceptance cycle is T0. data_o goes 0 at T0+1 (all outputs registered).
- START: data_o=0 for N cycles, then DATA with bit index 0.
- DATA:
  - data_o = shift[0] for N cycles per bit; shift right at each bit end; bit index increments.
  - After bit 7 completes: go to PARITY if PARITY_EN, else STOP.
- PARITY:
  - data_o = XOR of the latched byte, XORed with PARITY_ODD. Parity is computed at acceptance, not from the shifted data.
  - Lasts N cycles, then STOP.
- STOP:
  - data_o=1 for STOP_BITS*N cycles.
  - At the end of the last stop cycle: done_o=1, busy_o=0, return to IDLE.
- Frame length F = (1 + 8 + PARITY_EN + STOP_BITS) * N.
  - The line is driven from T0+1 to T0+F.
  - done_o rises at T0+F+1.
- The baud counter runs only while busy, counts 0..N-1, and wraps to 0 at bit end. The bit-end strobe is combinational from count == latched divisor.
- init_i while busy is ignored: no restart, no data re-latch, no error flag.
- init_i on the same cycle done_o would rise cannot occur (still busy). init_i on the cycle after return to IDLE is accepted: back-to-back frames with zero idle gap.
- done_o clears on the cycle after an accepted init_i, never on its own.
- Asynchronous reset mid-frame forces data_o=1 immediately. The partial frame is abandoned and done_o is not asserted.
- Default state arm returns to IDLE with data_o=1.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (3 bits: IDLE, START, DATA, PARITY, STOP).
  - UART_DATA_W = 8.
  - Shared parity function parity_calc(byte, odd) returning 1 bit.
  - The receiver gains parity checking later from the same function.
- One sub-module: uart_baud_tick.
  - 32-bit counter with enable and clear; emits a one-cycle tick when count equals the loaded divisor.
  - Reused later by the receiver refactor.

Test Plan:
- Send 0x55, baud_div=3 (N=4), PARITY_EN=0, STOP_BITS=1 -> data_o from T0+1: 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles (40 cycles); done_o rises at T0+41; busy_o high T0+1..T0+40.
- PARITY_EN=1 even, byte 0x07, N=2 -> parity bit 1 at cycles T0+19..T0+20; repeat with PARITY_ODD=1 -> parity bit 0; byte 0x00 even -> parity bit 0.
- STOP_BITS=2, byte 0xA3, N=1 -> frame 11 cycles; line high T0+10..T0+11; done_o at T0+12.
- Pulse init_i with 0xFF at T0+5 during a 0x12 frame -> waveform identical to the 0x12-only frame; busy_o unaffected; second init_i at the IDLE cycle starts 0xFF with no gap.
- Assert rst_n_i low mid-DATA -> data_o=1 and busy_o=0 asynchronously; done_o=0. After release, a 0x3C frame transmits correctly.
- Loopback into the existing receiver: 256 random bytes, baud_div=15 -> every received byte equals the sent byte; receiver done_o asserts once per frame.
